button_press_classifier: RTL and testbench
==========================================

// Module: button_press_classifier
// PURPOSE
//  Consumes the clean level from the debounce stage and classifies each button gesture.
//  Gesture classes: single short press, double press, long press, and auto-repeat while held.
//  Emits one-cycle event pulses for the UI/menu control logic downstream.
//  Single clock domain; the input is already synchronised and debounced.
// PARAMETERS
//  LONG_CYCLES       100000000  hold time (clk cycles after press) that makes a long press; >=2
//  DOUBLE_GAP_CYCLES 20000000   max release->next-press gap for a double press; 0 = double disabled
//  REPEAT_CYCLES     10000000   repeat_tick period while held after long press; >=1
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   asynchronous reset, active-low
//  debounced     in   1   stable button level (1 = pressed)
//  press_pulse   out  1   1-cycle pulse on every rising edge of debounced
//  release_pulse out  1   1-cycle pulse on every falling edge of debounced
//  short_press   out  1   1-cycle pulse: single short press confirmed
//  double_press  out  1   1-cycle pulse: second press of a pair released
//  long_press    out  1   1-cycle pulse: hold reached LONG_CYCLES
//  repeat_tick   out  1   1-cycle pulse every REPEAT_CYCLES while still held after long_press
// BEHAVIOUR
//  - Reset: one clock; reset is asynchronous and active-low (rst_n). All outputs 0, state IDLE.
//    Edge register prev=0, counter=0.
//    If debounced is high at reset release, this is a new press: press_pulse fires 1 cycle later.
//  - Edges: prev <= debounced; rise = debounced & ~prev; fall = ~debounced & prev.
//    All outputs are registered; press/release_pulse appear 1 cycle after debounced changes.
//  - Counter: 32-bit, cleared on every state entry, +1 per cycle, saturates at 2^32-1.
//  - Timing is stated from the cycle T of press_pulse or R of release_pulse.
//  - FSM:
//    IDLE:   rise -> PRESS1.
//    PRESS1: fall before T+LONG_CYCLES -> if DOUBLE_GAP_CYCLES==0: short_press at R and IDLE,
//            else WAIT_GAP.
//            Still high at T+LONG_CYCLES -> long_press at that cycle, LONG_HELD.
//    WAIT_GAP: rise seen so press_pulse lands before R+DOUBLE_GAP_CYCLES -> PRESS2 (no short).
//            Otherwise short_press at R+DOUBLE_GAP_CYCLES, IDLE.
//            Rise coinciding with expiry: the rise wins (PRESS2, no short_press).
//    PRESS2: fall -> double_press at R, IDLE. Hold duration is ignored (no long_press, no repeat).
//    LONG_HELD: repeat_tick at L+k*REPEAT_CYCLES (k>=1, L = long_press cycle) while held.
//            fall -> IDLE, release_pulse only (no short/double).
//  - At most one of short/double/long/repeat is high in any cycle.
//    press/release_pulse may coincide with short_press (DOUBLE_GAP_CYCLES==0) or double_press.
//  - Mid-operation reset: immediate return to reset values; no event is emitted for the aborted gesture.
// STRUCTURE
//  - Shared include button_defs.vh: FSM state encodings (IDLE, PRESS1, WAIT_GAP, PRESS2, LONG_HELD).
//    Also a default-timing localparam set for the 50 MHz board clock, reused by the debounce stage.
//  - Sub-module edge_detect: registered prev plus rise/fall pulse outputs, reset-able by rst_n.
//    The classifier FSM and counter stay in this module.
// TESTING  (LONG_CYCLES=20, DOUBLE_GAP_CYCLES=8, REPEAT_CYCLES=5)
//  1 Press high 6 cycles, release, stay low 20 -> press_pulse at T, release_pulse at R=T+6.
//    Then short_press once at R+8; no other events.
//  2 Press 4, low 3, press 4, release -> short_press never fires.
//    double_press once, same cycle as the second release_pulse.
//  3 Hold 32 cycles -> long_press at T+20, repeat_tick at T+25 and T+30.
//    On release: release_pulse only, no short_press.
//  4 Release, then re-press timed so press_pulse lands exactly at R+8 -> PRESS2, no short_press.
//    Re-press with press_pulse at R+9 -> short_press at R+8, then a new PRESS1.
//  5 Rerun with DOUBLE_GAP_CYCLES=0, press 3 and release -> short_press coincides with release_pulse.
//  6 Assert rst_n=0 during WAIT_GAP and during LONG_HELD -> all outputs 0 immediately.
//    No event after release of reset. Holding debounced=1 through reset gives press_pulse 1 cycle after release.

Source files
------------

// File: rtl/button_press_classifier_pkg.sv
// Shared definitions for the button gesture classifier: FSM states, event bundle,
// counter width and the default 50 MHz board timing also used by the debounce stage.
package button_press_classifier_pkg;

  localparam int unsigned CNT_W        = 32;
  localparam int unsigned BOARD_CLK_HZ = 50_000_000;

  // 2 s long press, 400 ms double-press gap, 200 ms auto-repeat at 50 MHz
  localparam int unsigned DEFAULT_LONG_CYCLES       = 2 * BOARD_CLK_HZ;
  localparam int unsigned DEFAULT_DOUBLE_GAP_CYCLES = (2 * BOARD_CLK_HZ) / 5;
  localparam int unsigned DEFAULT_REPEAT_CYCLES     = BOARD_CLK_HZ / 5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_WAIT_GAP  = 3'd2,
    ST_PRESS2    = 3'd3,
    ST_LONG_HELD = 3'd4
  } state_e;

  typedef struct packed {
    logic short_press;
    logic double_press;
    logic long_press;
    logic repeat_tick;
  } event_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + CNT_W'(1);
  endfunction

endpackage

// File: rtl/button_press_classifier_edge_detect.sv
// Edge register for the debounced button level: combinational rise/fall for the FSM
// and registered one-cycle press/release pulses for the outside world.
module button_press_classifier_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic debounced,
  output logic rise,
  output logic fall,
  output logic press_pulse,
  output logic release_pulse
);

  logic prev_q;
  logic prev_d;
  logic press_q;
  logic press_d;
  logic release_q;
  logic release_d;

  always_comb begin
    prev_d    = debounced;
    rise      = debounced & ~prev_q;
    fall      = ~debounced & prev_q;
    press_d   = rise;
    release_d = fall;
  end

  // prev resets to 0 so a button held through reset reads as a fresh press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced button gestures into short, double, long and auto-repeat
// events, each emitted as a registered one-cycle pulse.
module button_press_classifier
  import button_press_classifier_pkg::*;
#(
  parameter int unsigned LONG_CYCLES       = DEFAULT_LONG_CYCLES,
  parameter int unsigned DOUBLE_GAP_CYCLES = DEFAULT_DOUBLE_GAP_CYCLES,
  parameter int unsigned REPEAT_CYCLES     = DEFAULT_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic debounced,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_tick
);

  // Events are registered, so each decision is taken one count before its target cycle
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(DOUBLE_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic             GAP_EN      = (DOUBLE_GAP_CYCLES != 0);

  logic rise;
  logic fall;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             restart;
  event_t           ev_q;
  event_t           ev_d;

  button_press_classifier_edge_detect u_edge (
    .clk           (clk),
    .rst_n         (rst_n),
    .debounced     (debounced),
    .rise          (rise),
    .fall          (fall),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ev_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ev_q    <= ev_d;
    end
  end

  // A repeat tick re-enters LONG_HELD, restarting the count for the next period
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (fall)                    state_d = GAP_EN ? ST_WAIT_GAP : ST_IDLE;
        else if (cnt_q == LONG_LAST) state_d = ST_LONG_HELD;
      end
      ST_WAIT_GAP: begin
        if (rise)                   state_d = ST_PRESS2;
        else if (cnt_q == GAP_LAST) state_d = ST_IDLE;
      end
      ST_PRESS2: begin
        if (fall) state_d = ST_IDLE;
      end
      ST_LONG_HELD: begin
        if (fall)                      state_d = ST_IDLE;
        else if (cnt_q == REPEAT_LAST) restart = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    cnt_d = ((state_d != state_q) || restart) ? '0 : sat_inc(cnt_q);
  end

  // A rise arriving on the gap's last count wins over the pending short press
  always_comb begin
    ev_d = '0;
    case (state_q)
      ST_PRESS1: begin
        if (fall)                    ev_d.short_press = ~GAP_EN;
        else if (cnt_q == LONG_LAST) ev_d.long_press  = 1'b1;
      end
      ST_WAIT_GAP: begin
        if (!rise && (cnt_q == GAP_LAST)) ev_d.short_press = 1'b1;
      end
      ST_PRESS2: begin
        if (fall) ev_d.double_press = 1'b1;
      end
      ST_LONG_HELD: begin
        if (!fall && (cnt_q == REPEAT_LAST)) ev_d.repeat_tick = 1'b1;
      end
      default: ev_d = '0;
    endcase
  end

  assign short_press  = ev_q.short_press;
  assign double_press = ev_q.double_press;
  assign long_press   = ev_q.long_press;
  assign repeat_tick  = ev_q.repeat_tick;

endmodule

// File: tb/tb_button_press_classifier.sv
// Self-checking bench: two classifiers (double-press enabled and disabled) driven with
// directed and random button level waveforms, compared cycle by cycle with a gesture model.
module tb_button_press_classifier;

   localparam int LONG_C = 20;
   localparam int GAP_A  = 8;
   localparam int GAP_B  = 0;
   localparam int REP_C  = 5;
   localparam int MAXN   = 1024;

   localparam int B_PRESS  = 0;
   localparam int B_REL    = 1;
   localparam int B_SHORT  = 2;
   localparam int B_DOUBLE = 3;
   localparam int B_LONG   = 4;
   localparam int B_REPEAT = 5;

   logic clk;
   logic rst_n;
   logic debounced;

   logic press_a, rel_a, short_a, dbl_a, long_a, rep_a;
   logic press_b, rel_b, short_b, dbl_b, long_b, rep_b;
   logic [5:0] outs_a;
   logic [5:0] outs_b;

   int vectors;
   int miscompares;
   int cur_cycle;

   int         segs[$];
   bit         lvl[MAXN];
   int         n_cycles;
   logic [5:0] exp_ev[2][MAXN];

   button_press_classifier #(
      .LONG_CYCLES       (LONG_C),
      .DOUBLE_GAP_CYCLES (GAP_A),
      .REPEAT_CYCLES     (REP_C)
   ) dut_a (
      .clk           (clk),
      .rst_n         (rst_n),
      .debounced     (debounced),
      .press_pulse   (press_a),
      .release_pulse (rel_a),
      .short_press   (short_a),
      .double_press  (dbl_a),
      .long_press    (long_a),
      .repeat_tick   (rep_a)
   );

   button_press_classifier #(
      .LONG_CYCLES       (LONG_C),
      .DOUBLE_GAP_CYCLES (GAP_B),
      .REPEAT_CYCLES     (REP_C)
   ) dut_b (
      .clk           (clk),
      .rst_n         (rst_n),
      .debounced     (debounced),
      .press_pulse   (press_b),
      .release_pulse (rel_b),
      .short_press   (short_b),
      .double_press  (dbl_b),
      .long_press    (long_b),
      .repeat_tick   (rep_b)
   );

   assign outs_a = {rep_a, long_a, dbl_a, short_a, rel_a, press_a};
   assign outs_b = {rep_b, long_b, dbl_b, short_b, rel_b, press_b};

   // Free-running clock, 10 ns period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every vector and reports any miscompare
   task automatic checkOutput(input string tag, input logic [5:0] observed, input logic [5:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s cycle %0d: got {rep,long,dbl,short,rel,press}=%b, want %b",
                  tag, cur_cycle, observed, expected);
      end
   endtask

   // Expand alternating low/high segment lengths (starting low) into a per-cycle level array
   task automatic buildLevels();
      bit lv;
      lv = 1'b0;
      n_cycles = 0;
      foreach (segs[s]) begin
         for (int j = 0; j < segs[s]; j++) begin
            if (n_cycles < MAXN) begin
               lvl[n_cycles] = lv;
               n_cycles++;
            end
         end
         lv = ~lv;
      end
   endtask

   task automatic markEv(input int idx, input int e, input int b);
      if (e >= 0 && e < n_cycles) exp_ev[idx][e][b] = 1'b1;
   endtask

   // Gesture model: walk the list of press/release cycles and place events by arithmetic
   task automatic computeExpected(input int idx, input int gap);
      int  rises[$];
      int  falls[$];
      int  big;
      int  k;
      int  t_p;
      int  t_r;
      bit  prv;
      big = n_cycles + LONG_C + 1000;
      for (int i = 0; i < MAXN; i++) exp_ev[idx][i] = '0;
      for (int i = 0; i < n_cycles; i++) begin
         prv = (i == 0) ? 1'b0 : lvl[i-1];
         if (lvl[i] && !prv) begin
            rises.push_back(i);
            markEv(idx, i, B_PRESS);
         end
         if (!lvl[i] && prv) begin
            falls.push_back(i);
            markEv(idx, i, B_REL);
         end
      end
      k = 0;
      while (k < rises.size()) begin
         t_p = rises[k];
         t_r = (k < falls.size()) ? falls[k] : big;
         if (t_r > t_p + LONG_C) begin
            markEv(idx, t_p + LONG_C, B_LONG);
            for (int e = t_p + LONG_C + REP_C; e < t_r && e < n_cycles; e += REP_C)
               markEv(idx, e, B_REPEAT);
            k++;
         end else if (gap == 0) begin
            markEv(idx, t_r, B_SHORT);
            k++;
         end else if (k + 1 < rises.size() && rises[k+1] - t_r <= gap) begin
            markEv(idx, (k + 1 < falls.size()) ? falls[k+1] : big, B_DOUBLE);
            k += 2;
         end else begin
            markEv(idx, t_r + gap, B_SHORT);
            k++;
         end
      end
   endtask

   // Reset both DUTs, then play the level array; optionally assert reset mid-run at abort_at
   task automatic applyStimulus(input string tag, input int abort_at);
      buildLevels();
      computeExpected(0, GAP_A);
      computeExpected(1, GAP_B);
      cur_cycle = -1;
      rst_n = 1'b0;
      debounced = lvl[0];
      repeat (2) @(posedge clk);
      #1;
      checkOutput({tag, "/reset_a"}, outs_a, 6'b0);
      checkOutput({tag, "/reset_b"}, outs_b, 6'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < n_cycles; i++) begin
         @(posedge clk);
         #1;
         cur_cycle = i;
         checkOutput({tag, "/gap8"}, outs_a, exp_ev[0][i]);
         checkOutput({tag, "/gap0"}, outs_b, exp_ev[1][i]);
         if (abort_at >= 0 && i == abort_at) begin
            #2;
            rst_n = 1'b0;
            #1;
            checkOutput({tag, "/abort_a"}, outs_a, 6'b0);
            checkOutput({tag, "/abort_b"}, outs_b, 6'b0);
            break;
         end
         if (i + 1 < n_cycles) debounced = lvl[i+1];
      end
   endtask

   function automatic int randLow();
      case ($urandom_range(0, 2))
         0:       return $urandom_range(1, 4);
         1:       return $urandom_range(GAP_A - 1, GAP_A + 2);
         default: return $urandom_range(10, 30);
      endcase
   endfunction

   function automatic int randHigh();
      case ($urandom_range(0, 2))
         0:       return $urandom_range(1, 8);
         1:       return $urandom_range(LONG_C - 2, LONG_C + 3);
         default: return $urandom_range(LONG_C + 4, LONG_C + 25);
      endcase
   endfunction

   initial begin
      vectors     = 0;
      miscompares = 0;
      cur_cycle   = -1;
      rst_n       = 1'b0;
      debounced   = 1'b0;

      segs = {3, 6, 25};
      applyStimulus("short", -1);
      segs = {3, 4, 3, 4, 20};
      applyStimulus("double", -1);
      segs = {3, 32, 15};
      applyStimulus("long", -1);
      segs = {2, 5, GAP_A, 4, 20};
      applyStimulus("gap_edge", -1);
      segs = {2, 5, GAP_A + 1, 4, 20};
      applyStimulus("gap_over", -1);
      segs = {3, 3, 20};
      applyStimulus("short3", -1);
      segs = {2, 5, 20};
      applyStimulus("rst_gap", 10);
      segs = {2, 40, 10};
      applyStimulus("rst_long", 29);
      segs = {30};
      applyStimulus("post_rst", -1);
      segs = {0, 6, 20};
      applyStimulus("held_rst", -1);

      for (int r = 0; r < 20; r++) begin
         segs.delete();
         for (int s = 0; s < 5; s++) begin
            segs.push_back(randLow());
            segs.push_back(randHigh());
         end
         segs.push_back(LONG_C + GAP_A);
         applyStimulus($sformatf("rand%0d", r), -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
